// File: rtl/ram_ctrl_pkg.sv
// Shared opcodes, FSM state type and command-word width for the RAM sequencer.
package ram_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CMD_W      = DATA_W_DEF + 2;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT_RD,
        DONE
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signal bundle of the RAM arbiter.
interface ram_arbiter_if #(parameter int DATA_W = 8);

    logic [1:0]        req;
    logic [1:0]        we;
    logic [DATA_W-1:0] addr0;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              ram_rx_valid;
    logic [DATA_W+1:0] ram_din;
    logic              ram_tx_valid;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, ram_tx_valid, ram_dout,
        output gnt, done, rdata, err, busy, ram_rx_valid, ram_din
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, ram_tx_valid, ram_dout,
        input  gnt, done, rdata, err, busy, ram_rx_valid, ram_din
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-winner pointer.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    // Pointer starts at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_last <= 1'b1;
        else if (|o_gnt)
            r_last <= o_gnt[1];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a command-driven single-port RAM and
// sequences the addr-word / data-word protocol, with read timeout.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ram_arbiter_if.slave  bus
);
    // state   | meaning
    // IDLE    | waiting for a request, gnt may fire
    // ADDR    | address word on ram_din
    // DATA    | write-data or read-command word on ram_din
    // WAIT_RD | waiting for ram_tx_valid, timeout counter running
    // DONE    | done/err/rdata presented for one cycle

    localparam int CW    = DATA_W + 2;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t            r_state, w_state_n;
    logic              r_idx, r_we;
    logic [DATA_W-1:0] r_addr, r_wdata;
    logic [DATA_W-1:0] r_rdata, w_rdata_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic              r_rx_valid, w_rx_valid_n;
    logic [CW-1:0]     r_din, w_din_n;
    logic [1:0]        r_done, w_done_n;
    logic              r_err, w_err_n;
    logic              r_busy;

    logic [1:0]        w_gnt;
    logic              w_sel, w_sel_we;
    logic [DATA_W-1:0] w_sel_addr, w_sel_wdata;
    logic [1:0]        w_done_hot;

    rr_arbiter2 u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (r_state == IDLE),
        .i_req (bus.req),
        .o_gnt (w_gnt)
    );

    assign w_sel       = w_gnt[1];
    assign w_sel_we    = bus.we[w_sel];
    assign w_sel_addr  = w_sel ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_sel ? bus.wdata1 : bus.wdata0;
    assign w_done_hot  = r_idx ? 2'b10 : 2'b01;

    // Outputs are computed for the next state and registered (Moore).
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_rx_valid_n = 1'b0;
        w_din_n      = '0;
        w_done_n     = 2'b00;
        w_err_n      = 1'b0;
        w_rdata_n    = r_rdata;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_state_n    = ADDR;
                    w_rx_valid_n = 1'b1;
                    w_din_n      = {(w_sel_we ? WR_ADDR : RD_ADDR), w_sel_addr};
                end
            end
            ADDR: begin
                w_state_n    = DATA;
                w_rx_valid_n = 1'b1;
                w_din_n      = r_we ? {WR_DATA, r_wdata} : {RD_DATA, {DATA_W{1'b0}}};
            end
            DATA: begin
                if (r_we) begin
                    w_state_n = DONE;
                    w_done_n  = w_done_hot;
                end else begin
                    w_state_n = WAIT_RD;
                    w_cnt_n   = '0;
                end
            end
            WAIT_RD: begin
                if (bus.ram_tx_valid) begin
                    w_state_n = DONE;
                    w_done_n  = w_done_hot;
                    w_rdata_n = bus.ram_dout;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_n = DONE;
                    w_done_n  = w_done_hot;
                    w_err_n   = 1'b1;
                    w_rdata_n = '0;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            DONE: w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rx_valid <= 1'b0;
            r_din      <= '0;
            r_done     <= 2'b00;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_idx      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_rx_valid <= w_rx_valid_n;
            r_din      <= w_din_n;
            r_done     <= w_done_n;
            r_err      <= w_err_n;
            r_rdata    <= w_rdata_n;
            r_busy     <= (w_state_n != IDLE);
            if (r_state == IDLE && |w_gnt) begin
                r_idx   <= w_sel;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
        end
    end

    assign bus.gnt          = w_gnt;
    assign bus.done         = r_done;
    assign bus.rdata        = r_rdata;
    assign bus.err          = r_err;
    assign bus.busy         = r_busy;
    assign bus.ram_rx_valid = r_rx_valid;
    assign bus.ram_din      = r_din;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences the single-port, command-driven RAM on behalf of two independent requesters (SPI-slave side and a local agent).
- Arbitrates between them round-robin and turns each accepted transaction into the RAM's two-word command sequence: write = addr-word then data-word; read = addr-word then read-word, then wait for tx_valid.
- Returns read data or a timeout error to the winning requester.
- Sits between the requesters and the RAM's rx_valid/din/tx_valid/dout interface.

Parameters:
- DATA_W, 8, RAM address and data width; the command word is DATA_W+2 bits.
- TIMEOUT, 8, cycles to wait for ram_tx_valid after the read-word before flagging an error (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  2  per-requester request; held until gnt
- we  in  2  per-requester, 1=write, 0=read
- addr0, addr1  in  DATA_W  requester 0/1 address
- wdata0, wdata1  in  DATA_W  requester 0/1 write data
- gnt  out  2  one-hot accept pulse (combinational, IDLE only)
- done  out  2  one-hot completion pulse
- rdata  out  DATA_W  read result; valid while done is high for a read
- err  out  1  timeout flag; valid with done
- busy  out  1  high in every state except IDLE
- ram_rx_valid  out  1  command word valid to RAM
- ram_din  out  DATA_W+2  {opcode[1:0], payload}
- ram_tx_valid  in  1  RAM read-data valid
- ram_dout  in  DATA_W  RAM read data

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; ram_rx_valid=0, ram_din=0, done=0, err=0, rdata=0, busy=0.
  - RR pointer = requester 1 was last, so requester 0 wins the first tie.
  - Mid-operation reset aborts with no done; ram_rx_valid is low from the next cycle.
- Opcodes: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
- FSM states: IDLE, ADDR, DATA, WAIT_RD, DONE. All RAM-side outputs and done/err/rdata/busy are registered (Moore). gnt is the only combinational output.
- IDLE:
  - One requester requesting: grant it.
  - Both requesting: grant the one not most recently granted.
  - gnt[i]=1 for that cycle. Latch i, we[i], addr_i and wdata_i; update the RR pointer; go to ADDR.
  - No request: stay in IDLE.
- ADDR: ram_rx_valid=1, ram_din={we?00:10, addr}; go to DATA.
- DATA:
  - ram_rx_valid=1; ram_din={01,wdata} for a write, {11, all-zero} for a read.
  - Write: go to DONE. Read: go to WAIT_RD with the timeout counter cleared.
- WAIT_RD:
  - ram_rx_valid=0, ram_din=0.
  - ram_tx_valid=1: capture ram_dout into rdata, go to DONE with err=0.
  - Else, if counter==TIMEOUT-1: go to DONE with err=1 and rdata=0.
  - Else increment the counter.
- DONE: done[i]=1 and err valid for one cycle; return to IDLE. A new grant is possible in the following cycle (no back-to-back overlap).
- Latency, grant at cycle T: write done at T+3; read done at T+4 with the nominal 1-cycle RAM; read with timeout done at T+3+TIMEOUT.
- Boundaries:
  - req while busy: ignored, no gnt; the requester must hold req.
  - req dropped before gnt: no transaction.
  - ram_tx_valid outside WAIT_RD: ignored.
  - Address/data all-ones: passed unchanged.
  - The timeout counter is $clog2(TIMEOUT)+1 bits and never wraps.

Decomposition:
- ram_ctrl_pkg:
  - opcode localparams WR_ADDR/WR_DATA/RD_ADDR/RD_DATA
  - state enum (IDLE, ADDR, DATA, WAIT_RD, DONE)
  - CMD_W = DATA_W+2
- Sub-module rr_arbiter2: 2-way round-robin, combinational grant plus a registered last-grant pointer, update on accept, reset pointer=1.

Test Plan:
- Reset then single write: req=01, we=01, addr0=8'h3A, wdata0=8'h5C.
  - Expect gnt=01 in the same cycle.
  - ram_din=10'h03A then 10'h15C with rx_valid on 2 consecutive cycles; done=01 at T+3, err=0.
- Read with RAM model returning 8'hA7 one cycle after the read-word: req1 read, addr1=8'h10.
  - Expect ram_din=10'h210 then 10'h300.
  - done=10 at T+4, rdata=8'hA7, err=0.
- Simultaneous req=11 repeatedly, writes: grants alternate 01,10,01,10. After reset the first grant is 01. No gnt while busy=1.
- Read with tx_valid never asserted, TIMEOUT=8: done at T+11, err=1, rdata=0, then back to IDLE, next request accepted.
- rst asserted in DATA of a write: next cycle ram_rx_valid=0, busy=0, no done. Pending req re-granted to requester 0.
